// File: rtl/hpdmc_ddrseq_pkg.sv
// ============================================================================
//  Module   : hpdmc_ddrseq_pkg
//  Brief    : Shared state encoding and burst constants for the DDR sequencer
//  Revision : 1.0
// ============================================================================
`default_nettype none

package hpdmc_ddrseq_pkg;

    localparam int BURST_BEATS = 4;
    localparam int BEAT_W      = 2;
    localparam int CL_W        = 3;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_RWAIT = 3'd2,
        S_READ  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    // A CAS latency of zero cannot be honoured; it behaves as one.
    function automatic logic [CL_W-1:0] eff_cl(input logic [CL_W-1:0] cl);
        return (cl == '0) ? CL_W'(1) : cl;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hpdmc_ddrseq_burstcnt.sv
// ============================================================================
//  Module   : hpdmc_ddrseq_burstcnt
//  Brief    : Beat/burst counter; runs from start until the last beat of the
//             last burst has been ticked
//  Revision : 1.0
// ============================================================================
`default_nettype none

module hpdmc_ddrseq_burstcnt
    import hpdmc_ddrseq_pkg::*;
#(
    parameter int NB_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              tick,
    input  logic [NB_W-1:0]   nbursts,
    output logic              running,
    output logic [BEAT_W-1:0] beat,
    output logic              last
);

    logic              r_running;
    logic [BEAT_W-1:0] r_beat;
    logic [NB_W-1:0]   r_burst;

    // Burst index stops at nbursts, so an all-ones count never overflows.
    assign last    = r_running & (r_beat == LAST_BEAT) & (r_burst == nbursts);
    assign running = r_running;
    assign beat    = r_beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_running <= 1'b0;
            r_beat    <= '0;
            r_burst   <= '0;
        end else if (start) begin
            r_running <= 1'b1;
            r_beat    <= '0;
            r_burst   <= '0;
        end else if (tick && r_running) begin
            r_beat <= r_beat + BEAT_W'(1);
            if (last) begin
                r_running <= 1'b0;
            end else if (r_beat == LAST_BEAT) begin
                r_burst <= r_burst + NB_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/hpdmc_ddrseq.sv
// ============================================================================
//  Module   : hpdmc_ddrseq
//  Brief    : Sequences op_write/op_read and buffer strobes for DDR bursts,
//             with CAS latency and bus turnaround
//  Revision : 1.0
// ============================================================================
`default_nettype none

module hpdmc_ddrseq
    import hpdmc_ddrseq_pkg::*;
#(
    parameter int NB_W   = 3,
    parameter int TWTR   = 2,
    parameter int TRTW   = 1,
    parameter int RD_LAG = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    input  logic            cmd_write,
    input  logic [NB_W-1:0] cmd_nbursts,
    input  logic [CL_W-1:0] cfg_cl,
    output logic            cmd_ready,
    output logic            op_write,
    output logic            op_read,
    output logic            buffer_w_nextburst,
    output logic            buffer_w_next,
    output logic            buffer_r_nextburst,
    output logic            buffer_r_next,
    output logic            rd_valid,
    output logic            busy,
    output logic            done
);

    state_t          r_state;
    logic [3:0]      r_turn_cnt;
    logic            r_last_dir;
    logic [NB_W-1:0] r_nb;
    logic [CL_W-1:0] r_wait;
    logic [1:0]      r_tail;

    logic r_op_write, r_op_read, r_w_nb, r_w_next;
    logic r_r_nb, r_r_next, r_rd_valid, r_done;

    logic              w_accept;
    logic [CL_W-1:0]   w_cl;
    logic              w_rd_launch;
    logic              w_launch_start;
    logic              w_drain_start;
    logic              w_l_running, w_l_last;
    logic [BEAT_W-1:0] w_l_beat;
    logic              w_d_running, w_d_last;
    logic [BEAT_W-1:0] w_d_beat;

    assign cmd_ready = (r_state == S_IDLE) &
                       ((r_turn_cnt == 4'd0) | (cmd_write == r_last_dir));
    assign w_accept  = cmd_valid & cmd_ready;
    assign w_cl      = eff_cl(cfg_cl);

    // Read launch fires the cycle before the first op_read cycle.
    assign w_rd_launch = ((r_state == S_IDLE) & w_accept & ~cmd_write & (w_cl == CL_W'(1))) |
                         ((r_state == S_RWAIT) & (r_wait == '0));
    assign w_launch_start = ((r_state == S_IDLE) & w_accept & cmd_write) | w_rd_launch;

    generate
        if (RD_LAG == 1) begin : g_lag_none
            assign w_drain_start = w_rd_launch;
        end else begin : g_lag_pipe
            localparam int LAG_W = RD_LAG - 1;
            logic [LAG_W-1:0] r_lag;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_lag <= '0;
                end else begin
                    r_lag <= (r_lag << 1) | LAG_W'(w_rd_launch);
                end
            end
            assign w_drain_start = r_lag[LAG_W-1];
        end
    endgenerate

    hpdmc_ddrseq_burstcnt #(.NB_W(NB_W)) u_launch (
        .clk     (clk),
        .rst     (rst),
        .start   (w_launch_start),
        .tick    (1'b1),
        .nbursts (r_nb),
        .running (w_l_running),
        .beat    (w_l_beat),
        .last    (w_l_last)
    );

    hpdmc_ddrseq_burstcnt #(.NB_W(NB_W)) u_drain (
        .clk     (clk),
        .rst     (rst),
        .start   (w_drain_start),
        .tick    (1'b1),
        .nbursts (r_nb),
        .running (w_d_running),
        .beat    (w_d_beat),
        .last    (w_d_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_turn_cnt <= 4'd0;
            r_last_dir <= 1'b1;
            r_nb       <= '0;
            r_wait     <= '0;
            r_tail     <= 2'b00;
            r_op_write <= 1'b0;
            r_op_read  <= 1'b0;
            r_w_nb     <= 1'b0;
            r_w_next   <= 1'b0;
            r_r_nb     <= 1'b0;
            r_r_next   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_op_write <= 1'b0;
            r_op_read  <= 1'b0;
            r_w_nb     <= 1'b0;
            r_w_next   <= 1'b0;
            r_done     <= 1'b0;

            // Read strobes follow the drain counter; rd_valid trails them by one.
            r_r_nb     <= w_d_running & (w_d_beat == '0);
            r_r_next   <= w_d_running & (w_d_beat != '0);
            r_rd_valid <= r_r_nb | r_r_next;
            r_tail     <= {r_tail[0], w_d_last};

            if ((r_state == S_IDLE) && (r_turn_cnt != 4'd0)) begin
                r_turn_cnt <= r_turn_cnt - 4'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_nb <= cmd_nbursts;
                        if (cmd_write) begin
                            r_state <= S_WRITE;
                            r_w_nb  <= 1'b1;
                        end else if (w_cl == CL_W'(1)) begin
                            r_state   <= S_READ;
                            r_op_read <= 1'b1;
                        end else begin
                            r_state <= S_RWAIT;
                            r_wait  <= w_cl - CL_W'(2);
                        end
                    end
                end
                S_WRITE: begin
                    if (w_l_running) begin
                        r_op_write <= 1'b1;
                        r_w_nb     <= (w_l_beat == LAST_BEAT) & ~w_l_last;
                        r_w_next   <= (w_l_beat != LAST_BEAT);
                    end else begin
                        r_state    <= S_IDLE;
                        r_done     <= 1'b1;
                        r_turn_cnt <= 4'(TWTR);
                        r_last_dir <= 1'b1;
                    end
                end
                S_RWAIT: begin
                    if (r_wait == '0) begin
                        r_state   <= S_READ;
                        r_op_read <= 1'b1;
                    end else begin
                        r_wait <= r_wait - CL_W'(1);
                    end
                end
                S_READ: begin
                    r_op_read <= ~w_l_last;
                    if (w_l_last) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (r_tail[1]) begin
                        r_state    <= S_IDLE;
                        r_done     <= 1'b1;
                        r_turn_cnt <= 4'(TRTW);
                        r_last_dir <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign op_write           = r_op_write;
    assign op_read            = r_op_read;
    assign buffer_w_nextburst = r_w_nb;
    assign buffer_w_next      = r_w_next;
    assign buffer_r_nextburst = r_r_nb;
    assign buffer_r_next      = r_r_next;
    assign rd_valid           = r_rd_valid;
    assign busy               = (r_state != S_IDLE);
    assign done               = r_done;

endmodule

`default_nettype wire

// File: tb/tb_hpdmc_ddrseq.sv
// ============================================================================
//  Module   : tb_hpdmc_ddrseq
//  Brief    : Directed + randomized bench for hpdmc_ddrseq against a
//             cycle-timeline reference model
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hpdmc_ddrseq;

    localparam int NB_W   = 3;
    localparam int TWTR   = 2;
    localparam int TRTW   = 1;
    localparam int RD_LAG = 3;
    localparam int MAXC   = 4096;

    localparam int B_OPW  = 0;
    localparam int B_OPR  = 1;
    localparam int B_WNB  = 2;
    localparam int B_WN   = 3;
    localparam int B_RNB  = 4;
    localparam int B_RN   = 5;
    localparam int B_RDV  = 6;
    localparam int B_DONE = 7;
    localparam int B_BUSY = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_write;
    logic [NB_W-1:0] cmd_nbursts;
    logic [2:0]      cfg_cl;
    logic            cmd_ready;
    logic            op_write, op_read;
    logic            buffer_w_nextburst, buffer_w_next;
    logic            buffer_r_nextburst, buffer_r_next;
    logic            rd_valid, busy, done;

    always #5 clk = ~clk;

    hpdmc_ddrseq #(
        .NB_W   (NB_W),
        .TWTR   (TWTR),
        .TRTW   (TRTW),
        .RD_LAG (RD_LAG)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .cmd_valid          (cmd_valid),
        .cmd_write          (cmd_write),
        .cmd_nbursts        (cmd_nbursts),
        .cfg_cl             (cfg_cl),
        .cmd_ready          (cmd_ready),
        .op_write           (op_write),
        .op_read            (op_read),
        .buffer_w_nextburst (buffer_w_nextburst),
        .buffer_w_next      (buffer_w_next),
        .buffer_r_nextburst (buffer_r_nextburst),
        .buffer_r_next      (buffer_r_next),
        .rd_valid           (rd_valid),
        .busy               (busy),
        .done               (done)
    );

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         idle_from      = 0;
    int         turn_free_from = 0;
    bit         last_dir       = 1'b1;
    bit         accepted;
    logic [8:0] exp_v [MAXC];

    // Expected timeline: one bit per output per cycle, filled on each accept.
    function automatic void mark(int c, int b);
        if (c >= 0 && c < MAXC) exp_v[c][b] = 1'b1;
    endfunction

    function automatic bit model_ready(int c, bit w);
        return (c >= idle_from) && ((w == last_dir) || (c >= turn_free_from));
    endfunction

    function automatic void model_reset(int r);
        for (int c = r + 1; c < MAXC; c++) exp_v[c] = '0;
        idle_from      = r + 1;
        turn_free_from = r + 1;
        last_dir       = 1'b1;
    endfunction

    function automatic void model_accept(int t, bit w, int nb, int cfg);
        int n  = nb + 1;
        int cl = (cfg == 0) ? 1 : cfg;
        int d;
        int s;
        if (w) begin
            for (int b = 0; b < n; b++) begin
                mark(t + 1 + 4*b, B_WNB);
                for (int k = 2; k <= 4; k++) mark(t + k + 4*b, B_WN);
            end
            for (int c = t + 2; c <= t + 1 + 4*n; c++) mark(c, B_OPW);
            d = t + 2 + 4*n;
            turn_free_from = d + TWTR;
        end else begin
            for (int c = t + cl; c <= t + cl + 4*n - 1; c++) mark(c, B_OPR);
            for (int b = 0; b < n; b++) begin
                s = t + cl + RD_LAG + 4*b;
                mark(s, B_RNB);
                for (int k = 1; k <= 3; k++) mark(s + k, B_RN);
                for (int k = 1; k <= 4; k++) mark(s + k, B_RDV);
            end
            d = t + cl + RD_LAG + 4*n + 1;
            turn_free_from = d + TRTW;
        end
        mark(d, B_DONE);
        for (int c = t + 1; c < d; c++) mark(c, B_BUSY);
        idle_from = d;
        last_dir  = w;
    endfunction

    task automatic step();
        logic [8:0] obs;
        bit         rdy;
        @(negedge clk);
        accepted = 1'b0;
        if (rst) begin
            model_reset(cyc);
        end else if (cyc < MAXC) begin
            obs = {busy, done, rd_valid, buffer_r_next, buffer_r_nextburst,
                   buffer_w_next, buffer_w_nextburst, op_read, op_write};
            checks++;
            assert (obs === exp_v[cyc]) else begin
                failures++;
                $error("FAIL outputs cyc=%0d observed=%b expected=%b (busy,done,rdv,rn,rnb,wn,wnb,opr,opw)",
                       cyc, obs, exp_v[cyc]);
            end
            rdy = model_ready(cyc, cmd_write);
            checks++;
            assert (cmd_ready === rdy) else begin
                failures++;
                $error("FAIL cmd_ready cyc=%0d write=%0b observed=%b expected=%b",
                       cyc, cmd_write, cmd_ready, rdy);
            end
            if (cmd_valid && rdy) begin
                model_accept(cyc, cmd_write, int'(cmd_nbursts), int'(cfg_cl));
                accepted = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input bit w, input int nb, input int cl);
        bit got = 1'b0;
        cmd_valid   = 1'b1;
        cmd_write   = w;
        cmd_nbursts = nb[NB_W-1:0];
        cfg_cl      = cl[2:0];
        for (int i = 0; i < 300 && !got; i++) begin
            step();
            got = accepted;
        end
        checks++;
        assert (got) else begin
            failures++;
            $error("FAIL accept_timeout cyc=%0d observed=not_accepted expected=accepted", cyc);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic idle_steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    initial begin
        for (int c = 0; c < MAXC; c++) exp_v[c] = '0;
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_nbursts = '0;
        cfg_cl      = 3'd1;
        idle_steps(2);
        rst = 1'b0;

        // Idle after reset: ready for either direction, all outputs low.
        cmd_write = 1'b1; step();
        cmd_write = 1'b0; step();

        // Single-burst write, then a read held through the write->read turnaround.
        issue(1'b1, 0, 1);
        issue(1'b0, 1, 2);
        idle_steps(20);

        // Back-to-back writes, then a read after turnaround, then a write after read.
        issue(1'b1, 1, 1);
        issue(1'b1, 0, 1);
        issue(1'b0, 0, 3);
        issue(1'b1, 2, 1);
        idle_steps(10);

        // CAS latency zero vs one, with the maximum burst count.
        issue(1'b0, 7, 0);
        issue(1'b0, 7, 1);
        idle_steps(10);

        // Reset while op_read is active aborts the read.
        issue(1'b0, 7, 3);
        idle_steps(6);
        rst = 1'b1; step();
        rst = 1'b0;
        cmd_write = 1'b0; step();
        cmd_write = 1'b1; step();

        // Random back-to-back reads.
        for (int i = 0; i < 12; i++) begin
            issue(1'b0, int'($urandom_range(0, 7)), int'($urandom_range(1, 7)));
        end
        // Random mixed traffic, including cfg_cl = 0.
        for (int i = 0; i < 16; i++) begin
            issue(bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)));
        end
        idle_steps(60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
